pkt_addr_gen: RTL and testbench

Transmit-direction companion to the receive-path TLAST generator. Takes the beat handshake and TLAST of an outbound AXI-Stream packet and emits one buffer address per beat, restarting at BASE_ADDR for every packet and incrementing by the bus width. At each TLAST it publishes a byte-length descriptor for the PS, which programs the GEM TX DMA. The number of packets resident in the buffer is credit-limited; the PS returns a credit when the GEM reports TX complete.

---
 rtl/pkt_addr_gen_if.sv | 28 ++
 rtl/pkt_addr_gen.sv | 131 +++++++++++++
 tb/tb_pkt_addr_gen.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_addr_gen_if.sv
// Beat, address and descriptor handshakes of the TX buffer address generator.
// The slave side is the generator; the master side is the stream source/sinks.
interface pkt_addr_gen_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  s_tvalid;
    logic                  s_tlast;
    logic                  s_tready;
    logic [ADDR_WIDTH-1:0] o_addr_data;
    logic                  o_addr_valid;
    logic                  i_addr_ready;
    logic [15:0]           o_len_bytes;
    logic                  o_len_trunc;
    logic                  o_len_valid;
    logic                  i_len_ready;

    modport master (
        output s_tvalid, s_tlast, i_addr_ready, i_len_ready,
        input  s_tready, o_addr_data, o_addr_valid,
        input  o_len_bytes, o_len_trunc, o_len_valid
    );

    modport slave (
        input  s_tvalid, s_tlast, i_addr_ready, i_len_ready,
        output s_tready, o_addr_data, o_addr_valid,
        output o_len_bytes, o_len_trunc, o_len_valid
    );
endinterface

// File: rtl/pkt_addr_gen.sv
// Per-beat buffer address generator for outbound packets, with a length
// descriptor per packet and a credit limit on packets resident in the buffer.
module pkt_addr_gen #(
    parameter int ADDR_WIDTH      = 12,
    parameter int BUS_WIDTH       = 32,
    parameter int BASE_ADDR       = 0,
    parameter int BUF_BYTES       = 2048,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    pkt_addr_gen_if.slave                      bus,
    input  logic                               i_pkt_consumed,
    output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [15:0] BEAT = 16'(BUS_WIDTH / 8);
    localparam logic [15:0] BUFB = 16'(BUF_BYTES);
    localparam logic [CW-1:0] MAXO = CW'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic {IDLE, BODY} state_t;

    state_t                state;
    state_t                state_nx;
    logic [15:0]           offset;
    logic [15:0]           offset_nx;
    logic                  trunc;
    logic                  out_free;
    logic                  len_free;
    logic                  credit_ok;
    logic                  accept;
    logic                  room;
    logic                  emit;
    logic                  inc;
    logic                  dec;
    logic [ADDR_WIDTH-1:0] addr_nx;

    // Handshake qualification and next-state decode.
    always_comb begin
        state_nx  = state;
        out_free  = !bus.o_addr_valid || bus.i_addr_ready;
        len_free  = !bus.o_len_valid || bus.i_len_ready;
        credit_ok = (state == BODY) || (o_outstanding < MAXO);
        bus.s_tready = out_free && credit_ok && (!bus.s_tlast || len_free);
        accept    = bus.s_tvalid && bus.s_tready;
        room      = (state == IDLE) || (offset < BUFB);
        emit      = accept && room;
        offset_nx = offset;
        addr_nx   = BASE;
        inc       = 1'b0;
        dec       = i_pkt_consumed && (o_outstanding != '0);
        case (state)
            IDLE: begin
                offset_nx = BEAT;
                addr_nx   = BASE;
                inc       = accept;
                if (accept && !bus.s_tlast)
                    state_nx = BODY;
            end
            BODY: begin
                addr_nx = BASE + ADDR_WIDTH'(offset);
                if (room)
                    offset_nx = offset + BEAT;
                if (accept && bus.s_tlast)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Packet state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Byte offset within the packet and sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            offset <= '0;
            trunc  <= 1'b0;
        end else if (accept) begin
            offset <= offset_nx;
            if (bus.s_tlast)
                trunc <= 1'b0;
            else if (!room)
                trunc <= 1'b1;
        end
    end

    // Address output register; holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.o_addr_valid <= 1'b0;
            bus.o_addr_data  <= '0;
        end else if (emit) begin
            bus.o_addr_valid <= 1'b1;
            bus.o_addr_data  <= addr_nx;
        end else if (bus.i_addr_ready) begin
            bus.o_addr_valid <= 1'b0;
        end
    end

    // Length descriptor register, loaded on the last beat of a packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.o_len_valid <= 1'b0;
            bus.o_len_bytes <= '0;
            bus.o_len_trunc <= 1'b0;
        end else if (accept && bus.s_tlast) begin
            bus.o_len_valid <= 1'b1;
            bus.o_len_bytes <= offset_nx;
            bus.o_len_trunc <= (state == BODY) && (trunc || !room);
        end else if (bus.i_len_ready) begin
            bus.o_len_valid <= 1'b0;
        end
    end

    // Credit counter of packets held in the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            o_outstanding <= '0;
        else if (inc && !dec)
            o_outstanding <= o_outstanding + 1'b1;
        else if (dec && !inc)
            o_outstanding <= o_outstanding - 1'b1;
    end
endmodule

// File: tb/tb_pkt_addr_gen.sv
// Directed bench for pkt_addr_gen: address sequences, descriptors,
// credit stall, truncation, backpressure and mid-packet reset.
module tb_pkt_addr_gen;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       i_pkt_consumed = 1'b0;
    logic [2:0] o_outstanding;

    pkt_addr_gen_if #(.ADDR_WIDTH(12)) bus ();

    pkt_addr_gen #(
        .ADDR_WIDTH(12), .BUS_WIDTH(32), .BASE_ADDR(0),
        .BUF_BYTES(2048), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .i_pkt_consumed(i_pkt_consumed),
        .o_outstanding(o_outstanding)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          stall_bad = 0;
    logic        rand_rdy = 1'b0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_addr = '0;
    logic [31:0] aq[$];
    logic [31:0] lq[$];
    logic [31:0] ea[$];
    logic [31:0] el[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input logic [31:0] got[$],
                         input logic [31:0] exp[$]);
        chk({tag, "_n"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (reset_n) begin
            if (prev_stall && (!bus.o_addr_valid || bus.o_addr_data !== prev_addr))
                stall_bad++;
            if (bus.o_addr_valid && bus.i_addr_ready)
                aq.push_back(32'(bus.o_addr_data));
            if (bus.o_len_valid && bus.i_len_ready)
                lq.push_back(32'({bus.o_len_trunc, bus.o_len_bytes}));
            prev_stall = bus.o_addr_valid && !bus.i_addr_ready;
            prev_addr = bus.o_addr_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy)
            bus.i_addr_ready = 1'($urandom_range(0, 1));
    end

    task automatic do_reset();
        reset_n = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast = 1'b0;
        i_pkt_consumed = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        aq.delete();
        lq.delete();
        ea.delete();
        el.delete();
    endtask

    task automatic beat(input logic last);
        int n;
        n = 0;
        bus.s_tvalid = 1'b1;
        bus.s_tlast = last;
        #1;
        while (!bus.s_tready && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 300)
            chk("beat_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #2;
        bus.s_tvalid = 1'b0;
        bus.s_tlast = 1'b0;
    endtask

    task automatic drain();
        rand_rdy = 1'b0;
        #1;
        bus.i_addr_ready = 1'b1;
        bus.i_len_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int hold1;
        bus.s_tvalid = 1'b0;
        bus.s_tlast = 1'b0;
        bus.i_addr_ready = 1'b1;
        bus.i_len_ready = 1'b1;
        do_reset();

        chk("rst_addr_valid", 32'(bus.o_addr_valid), 32'd0);
        chk("rst_addr_data", 32'(bus.o_addr_data), 32'd0);
        chk("rst_len_valid", 32'(bus.o_len_valid), 32'd0);
        chk("rst_len_bytes", 32'(bus.o_len_bytes), 32'd0);
        chk("rst_len_trunc", 32'(bus.o_len_trunc), 32'd0);
        chk("rst_outstanding", 32'(o_outstanding), 32'd0);

        // 64-byte packet
        c0 = cyc;
        for (int i = 0; i < 16; i++)
            beat(i == 15);
        chk("t1_cycles", 32'(cyc - c0), 32'd16);
        chk("t1_last_addr", 32'(bus.o_addr_data), 32'h03C);
        chk("t1_len_valid", 32'(bus.o_len_valid), 32'd1);
        chk("t1_len_bytes", 32'(bus.o_len_bytes), 32'd64);
        chk("t1_len_trunc", 32'(bus.o_len_trunc), 32'd0);
        chk("t1_outstanding", 32'(o_outstanding), 32'd1);
        drain();
        for (int i = 0; i < 16; i++)
            ea.push_back(32'(4 * i));
        el.push_back(32'd64);
        cmp_q("t1_addrs", aq, ea);
        cmp_q("t1_lens", lq, el);

        // back-to-back 8 B and 12 B packets
        do_reset();
        beat(1'b0); beat(1'b1);
        beat(1'b0); beat(1'b0); beat(1'b1);
        drain();
        ea.push_back(32'd0); ea.push_back(32'd4);
        ea.push_back(32'd0); ea.push_back(32'd4); ea.push_back(32'd8);
        el.push_back(32'd8); el.push_back(32'd12);
        cmp_q("t2_addrs", aq, ea);
        cmp_q("t2_lens", lq, el);
        chk("t2_outstanding", 32'(o_outstanding), 32'd2);

        // credit stall
        do_reset();
        for (int i = 0; i < 4; i++)
            beat(1'b1);
        chk("t3_full", 32'(o_outstanding), 32'd4);
        bus.s_tvalid = 1'b1;
        bus.s_tlast = 1'b1;
        #1;
        chk("t3_stall0", 32'(bus.s_tready), 32'd0);
        @(posedge clk);
        #2;
        chk("t3_stall1", 32'(bus.s_tready), 32'd0);
        i_pkt_consumed = 1'b1;
        @(posedge clk);
        #2;
        i_pkt_consumed = 1'b0;
        #1;
        chk("t3_freed", 32'(o_outstanding), 32'd3);
        chk("t3_ready", 32'(bus.s_tready), 32'd1);
        @(posedge clk);
        #2;
        bus.s_tvalid = 1'b0;
        bus.s_tlast = 1'b0;
        chk("t3_refill", 32'(o_outstanding), 32'd4);
        chk("t3_addr_valid", 32'(bus.o_addr_valid), 32'd1);
        chk("t3_addr", 32'(bus.o_addr_data), 32'd0);
        drain();
        for (int i = 0; i < 5; i++) begin
            ea.push_back(32'd0);
            el.push_back(32'd4);
        end
        cmp_q("t3_addrs", aq, ea);
        cmp_q("t3_lens", lq, el);

        // 2056-byte packet into a 2048-byte buffer
        do_reset();
        for (int i = 0; i < 514; i++)
            beat(i == 513);
        chk("t4_len_bytes", 32'(bus.o_len_bytes), 32'd2048);
        chk("t4_len_trunc", 32'(bus.o_len_trunc), 32'd1);
        drain();
        for (int i = 0; i < 512; i++)
            ea.push_back(32'(4 * i));
        el.push_back(32'h10800);
        cmp_q("t4_addrs", aq, ea);
        cmp_q("t4_lens", lq, el);

        // random address backpressure, descriptor held
        do_reset();
        stall_bad = 0;
        bus.i_len_ready = 1'b0;
        rand_rdy = 1'b1;
        beat(1'b0); beat(1'b0); beat(1'b1);
        beat(1'b0);
        bus.s_tvalid = 1'b1;
        bus.s_tlast = 1'b1;
        hold1 = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #3;
            if (bus.s_tready)
                hold1++;
        end
        chk("t5_tlast_held", 32'(hold1), 32'd0);
        chk("t5_no_len", 32'(lq.size()), 32'd0);
        bus.i_len_ready = 1'b1;
        #1;
        beat(1'b1);
        drain();
        chk("t5_stable", 32'(stall_bad), 32'd0);
        ea.push_back(32'd0); ea.push_back(32'd4); ea.push_back(32'd8);
        ea.push_back(32'd0); ea.push_back(32'd4);
        el.push_back(32'd12); el.push_back(32'd8);
        cmp_q("t5_addrs", aq, ea);
        cmp_q("t5_lens", lq, el);

        // reset mid-packet
        do_reset();
        beat(1'b0); beat(1'b0); beat(1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_addr_valid", 32'(bus.o_addr_valid), 32'd0);
        chk("t6_addr_data", 32'(bus.o_addr_data), 32'd0);
        chk("t6_outstanding", 32'(o_outstanding), 32'd0);
        chk("t6_len_valid", 32'(bus.o_len_valid), 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        aq.delete();
        lq.delete();
        beat(1'b0); beat(1'b1);
        drain();
        ea.push_back(32'd0); ea.push_back(32'd4);
        el.push_back(32'd8);
        cmp_q("t6_addrs", aq, ea);
        cmp_q("t6_lens", lq, el);
        chk("t6_new_count", 32'(o_outstanding), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
